// File: rtl/cmd_queue.sv
// Command descriptor queue {instr, payload_len} between the UART parser and the JTAG sequencer.
// First-word-fall-through head, almost-full threshold, flush, sticky error flags, running byte total.
module cmd_queue #(
   parameter  int DEPTH        = 32,
   parameter  int INSTR_W      = 4,
   parameter  int LEN_W        = 8,
   parameter  int AFULL_THRESH = 4,
   localparam int AW           = $clog2(DEPTH),
   localparam int PW           = AW + 1,
   localparam int BW           = LEN_W + AW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               wr_en,
   input  logic [INSTR_W-1:0] instr,
   input  logic [LEN_W-1:0]   payload_len,
   output logic               full,
   output logic               almost_full,
   output logic [PW-1:0]      free,
   input  logic               rd_en,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [LEN_W-1:0]   out_len,
   output logic               empty,
   output logic [PW-1:0]      count,
   output logic [BW-1:0]      pending_bytes,
   output logic               overflow,
   output logic               underflow,
   input  logic               err_clr
);

   localparam int DW = INSTR_W + LEN_W;

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [BW-1:0] r_pending;
   logic          r_overflow;
   logic          r_underflow;

   logic [PW-1:0] w_count;
   logic [PW-1:0] w_free;
   logic          w_full;
   logic          w_empty;
   logic          w_wr_acc;
   logic          w_rd_acc;
   logic          w_ov_evt;
   logic          w_un_evt;
   logic [DW-1:0] w_head;
   logic [BW-1:0] w_add;
   logic [BW-1:0] w_sub;

   // Wrap bit distinguishes full (indices equal, laps differ) from empty (pointers equal).
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_free  = PW'(DEPTH) - w_count;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

   assign w_wr_acc = wr_en && !w_full  && !flush;
   assign w_rd_acc = rd_en && !w_empty && !flush;
   assign w_ov_evt = wr_en &&  w_full  && !flush;
   assign w_un_evt = rd_en &&  w_empty && !flush;

   assign w_head = r_mem[r_rd_ptr[AW-1:0]];
   assign w_add  = w_wr_acc ? BW'(payload_len)       : '0;
   assign w_sub  = w_rd_acc ? BW'(w_head[LEN_W-1:0]) : '0;

   // NOTE: the storage array has no reset; the pointers alone decide which words are live.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {instr, payload_len};
      end
   end

   // NOTE: non-blocking updates so pointers, byte total and flags all see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_pending <= '0;
      end else if (flush) begin
         r_rd_ptr  <= r_wr_ptr;
         r_pending <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
         r_pending <= r_pending + w_add - w_sub;
      end
   end

   // A new error event in the same cycle as err_clr leaves its flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= (r_overflow  && !err_clr) || w_ov_evt;
         r_underflow <= (r_underflow && !err_clr) || w_un_evt;
      end
   end

   assign full          = w_full;
   assign empty         = w_empty;
   assign count         = w_count;
   assign free          = w_free;
   assign almost_full   = (w_free <= PW'(AFULL_THRESH));
   assign out_valid     = !w_empty;
   assign out_instr     = w_empty ? '0 : w_head[DW-1:LEN_W];
   assign out_len       = w_empty ? '0 : w_head[LEN_W-1:0];
   assign pending_bytes = r_pending;
   assign overflow      = r_overflow;
   assign underflow     = r_underflow;

endmodule

// File: tb/tb_cmd_queue.sv
// Self-checking bench for cmd_queue: directed scenarios plus randomized traffic against a queue model.
module tb_cmd_queue;

   localparam int DEPTH        = 32;
   localparam int INSTR_W      = 4;
   localparam int LEN_W        = 8;
   localparam int AFULL_THRESH = 4;
   localparam int PW           = $clog2(DEPTH) + 1;
   localparam int BW           = LEN_W + $clog2(DEPTH);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               flush;
   logic               wr_en;
   logic [INSTR_W-1:0] instr;
   logic [LEN_W-1:0]   payload_len;
   logic               rd_en;
   logic               err_clr;
   logic               full;
   logic               almost_full;
   logic [PW-1:0]      free;
   logic               out_valid;
   logic [INSTR_W-1:0] out_instr;
   logic [LEN_W-1:0]   out_len;
   logic               empty;
   logic [PW-1:0]      count;
   logic [BW-1:0]      pending_bytes;
   logic               overflow;
   logic               underflow;

   cmd_queue #(
      .DEPTH        (DEPTH),
      .INSTR_W      (INSTR_W),
      .LEN_W        (LEN_W),
      .AFULL_THRESH (AFULL_THRESH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .wr_en         (wr_en),
      .instr         (instr),
      .payload_len   (payload_len),
      .full          (full),
      .almost_full   (almost_full),
      .free          (free),
      .rd_en         (rd_en),
      .out_valid     (out_valid),
      .out_instr     (out_instr),
      .out_len       (out_len),
      .empty         (empty),
      .count         (count),
      .pending_bytes (pending_bytes),
      .overflow      (overflow),
      .underflow     (underflow),
      .err_clr       (err_clr)
   );

   typedef struct {
      int instr;
      int len;
   } cmd_t;

   cmd_t m_q[$];
   int   m_pending;
   bit   m_ov;
   bit   m_un;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Queue-level model: evaluated once per rising edge using the occupancy before that edge.
   task automatic model_step();
      bit was_full;
      bit was_empty;
      if (rst) begin
         m_q.delete();
         m_pending = 0;
         m_ov = 0;
         m_un = 0;
      end else begin
         if (err_clr) begin
            m_ov = 0;
            m_un = 0;
         end
         if (flush) begin
            m_q.delete();
            m_pending = 0;
         end else begin
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            if (wr_en && was_full)  m_ov = 1;
            if (rd_en && was_empty) m_un = 1;
            if (rd_en && !was_empty) begin
               m_pending -= m_q[0].len;
               void'(m_q.pop_front());
            end
            if (wr_en && !was_full) begin
               m_q.push_back(cmd_t'{instr: int'(instr), len: int'(payload_len)});
               m_pending += int'(payload_len);
            end
         end
      end
   endtask

   task automatic check_all();
      int n = m_q.size();
      check("empty",       empty,         n == 0);
      check("out_valid",   out_valid,     n != 0);
      check("full",        full,          n == DEPTH);
      check("count",       count,         n);
      check("free",        free,          DEPTH - n);
      check("almost_full", almost_full,   (DEPTH - n) <= AFULL_THRESH);
      check("out_instr",   out_instr,     (n != 0) ? m_q[0].instr : 0);
      check("out_len",     out_len,       (n != 0) ? m_q[0].len : 0);
      check("pending",     pending_bytes, m_pending);
      check("overflow",    overflow,      m_ov);
      check("underflow",   underflow,     m_un);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      rst = 0; flush = 0; wr_en = 0; rd_en = 0; err_clr = 0;
      instr = '0; payload_len = '0;
   endtask

   task automatic push(input int i, input int l);
      idle();
      wr_en = 1; instr = INSTR_W'(i); payload_len = LEN_W'(l);
      cycle();
      idle();
   endtask

   task automatic pop();
      idle();
      rd_en = 1;
      cycle();
      idle();
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      cycle();
      idle();
   endtask

   initial begin
      int sum;
      idle();
      do_reset();
      do_reset();
      check("rst_free",  free, DEPTH);
      check("rst_empty", empty, 1);
      check("rst_afull", almost_full, 0);

      // Three pushes, then one pop.
      push(1, 10); push(2, 20); push(3, 30);
      check("t1_count", count, 3);
      check("t1_pend",  pending_bytes, 60);
      check("t1_hi",    out_instr, 1);
      check("t1_hl",    out_len, 10);
      pop();
      check("t1_pop_hi",   out_instr, 2);
      check("t1_pop_hl",   out_len, 20);
      check("t1_pop_pend", pending_bytes, 50);
      check("t1_pop_free", free, DEPTH - 2);

      // Fill to the almost-full threshold, then to full, then overflow.
      do_reset();
      sum = 0;
      for (int i = 0; i < 28; i++) begin
         push(i % 16, (i * 7 + 3) % 256);
         sum += (i * 7 + 3) % 256;
      end
      check("t2_afull", almost_full, 1);
      check("t2_nfull", full, 0);
      for (int i = 28; i < 32; i++) begin
         push(i % 16, (i * 7 + 3) % 256);
         sum += (i * 7 + 3) % 256;
      end
      check("t2_full", full, 1);
      check("t2_free0", free, 0);
      push(7, 99);
      check("t2_ovf",   overflow, 1);
      check("t2_cnt",   count, 32);
      check("t2_pend",  pending_bytes, sum);

      // Full queue: simultaneous read and write; the write is dropped.
      idle(); wr_en = 1; rd_en = 1; instr = 4'd9; payload_len = 8'd77;
      cycle(); idle();
      check("t3_cnt", count, 31);
      check("t3_ovf", overflow, 1);
      idle(); err_clr = 1; cycle(); idle();
      check("t3_clr", overflow, 0);

      // Empty queue: write and read together.
      idle(); flush = 1; cycle(); idle();
      check("t4_flush_empty", empty, 1);
      idle(); wr_en = 1; rd_en = 1; instr = 4'd5; payload_len = 8'd8;
      cycle(); idle();
      check("t4_cnt", count, 1);
      check("t4_hi",  out_instr, 5);
      check("t4_hl",  out_len, 8);
      check("t4_udf", underflow, 1);

      // Streaming: 50 entries push/pop alternating, then 50 with wr_en and rd_en held together.
      do_reset();
      for (int i = 0; i < 50; i++) begin
         push($urandom_range(15), $urandom_range(255));
         check("t5_cnt_le1", count <= 1, 1);
         pop();
      end
      idle(); wr_en = 1; instr = INSTR_W'($urandom); payload_len = LEN_W'($urandom);
      cycle();
      for (int i = 1; i < 50; i++) begin
         rd_en = 1; wr_en = 1;
         instr = INSTR_W'($urandom); payload_len = LEN_W'($urandom);
         cycle();
         check("t5_cnt_le1", count <= 1, 1);
      end
      pop();
      check("t5_drained", empty, 1);

      // Flush with a concurrent write/read, then reset mid-stream.
      pop();
      check("t6_udf_set", underflow, 1);
      for (int i = 0; i < 10; i++) push(i, 100 + i);
      check("t6_cnt10", count, 10);
      idle(); flush = 1; wr_en = 1; rd_en = 1; instr = 4'd3; payload_len = 8'd44;
      cycle(); idle();
      check("t6_empty", empty, 1);
      check("t6_cnt",   count, 0);
      check("t6_pend",  pending_bytes, 0);
      check("t6_ovf",   overflow, 0);
      check("t6_udf",   underflow, 1);
      push(1, 1); push(2, 2); push(3, 3);
      idle(); rst = 1; wr_en = 1; instr = 4'd4; payload_len = 8'd4;
      cycle(); idle();
      check("t6_rst_empty", empty, 1);
      check("t6_rst_free",  free, DEPTH);
      check("t6_rst_udf",   underflow, 0);

      // Randomized traffic with alternating fill/drain bias.
      for (int i = 0; i < 4000; i++) begin
         int wr_pct;
         int r;
         wr_pct = ((i / 150) % 2 == 0) ? 80 : 25;
         idle();
         wr_en       = ($urandom_range(99) < wr_pct);
         rd_en       = ($urandom_range(99) < (100 - wr_pct));
         instr       = INSTR_W'($urandom);
         payload_len = LEN_W'($urandom);
         r = $urandom_range(999);
         if (r < 8)       flush   = 1;
         else if (r < 30) err_clr = 1;
         else if (r < 32) rst     = 1;
         cycle();
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cmd_queue.md
Name: cmd_queue

Overview:
Parametrised command queue holding {instr, payload_len} descriptors between the UART command parser and the JTAG sequencer.
- Owns its storage directly; does not wrap a generic FIFO.
- First-word-fall-through head.
- Adds almost-full threshold, flush, sticky overflow/underflow error flags and a running total of queued payload bytes, so the parser can throttle on payload-buffer space as well as on slot count.

Parameters:
DEPTH, 32, number of command slots; power of two, >= 2
INSTR_W, 4, instruction id width
LEN_W, 8, payload length field width
AFULL_THRESH, 4, almost_full asserts when free <= AFULL_THRESH; range 0..DEPTH-1
(PW = $clog2(DEPTH)+1, BW = LEN_W+$clog2(DEPTH))

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  discard all queued entries
wr_en  in  1  push request
instr  in  INSTR_W  instruction id to push
payload_len  in  LEN_W  payload length to push
full  out  1  no free slot
almost_full  out  1  free <= AFULL_THRESH
free  out  PW  free slots, 0..DEPTH
rd_en  in  1  pop request (acknowledges current head)
out_valid  out  1  head entry valid (= !empty)
out_instr  out  INSTR_W  head instruction id
out_len  out  LEN_W  head payload length
empty  out  1  no entries
count  out  PW  occupied slots, 0..DEPTH
pending_bytes  out  BW  sum of payload_len over all queued entries
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
err_clr  in  1  clear sticky error flags

Behaviour:
- Storage and pointers:
  - Array of DEPTH words of INSTR_W+LEN_W bits.
  - wr_ptr/rd_ptr are PW bits; the MSB is the wrap bit.
  - full when the indices are equal and the wrap bits differ; empty when the pointers are equal.
  - count = wr_ptr - rd_ptr (modulo 2^PW). free = DEPTH - count.
  - full, empty, almost_full, free and count are combinational from registered state.
- Reset (rst=1 at a clk edge): pointers=0, pending_bytes=0, overflow=0, underflow=0.
  - Resulting outputs: empty=1, out_valid=0, full=0, free=DEPTH, count=0, almost_full=(DEPTH<=AFULL_THRESH)=0.
  - Array contents are not reset. out_instr/out_len are forced to 0 while empty.
- Write accept: wr_en && !full, with full evaluated on pre-edge state.
  - A simultaneous read does not make room the same cycle.
  - On accept: store at wr_ptr, increment wr_ptr, pending_bytes += payload_len.
  - Write while full: data dropped, state unchanged, overflow set.
- Read accept: rd_en && !empty, with empty evaluated on pre-edge state.
  - On accept: increment rd_ptr, pending_bytes -= out_len.
  - Read while empty: ignored, underflow set.
  - A simultaneous write into an empty queue is accepted, and the read still counts as underflow.
- Simultaneous accepted read and write: count unchanged; pending_bytes += payload_len - out_len in one update.
- FWFT latency:
  - Write accepted at edge N: out_valid=1 and the head shows the entry after edge N, provided the queue was empty.
  - Pop at edge N: the next entry is presented after edge N.
  - Combinational read of array[rd_ptr] is permitted.
- Pointer wrap: indices wrap DEPTH-1 -> 0 and the wrap bit toggles. No special case is needed at any DEPTH.
- pending_bytes cannot overflow: BW covers DEPTH*(2^LEN_W-1).
- flush:
  - At an edge, rd_ptr <= wr_ptr and pending_bytes <= 0.
  - A wr_en/rd_en in the same cycle is discarded and does not set overflow/underflow.
  - Sticky flags are not cleared by flush.
- err_clr:
  - Clears overflow/underflow at the edge.
  - If a new error event occurs the same cycle, that flag ends set.
- Priority: rst > flush > normal operation.

Test Plan:
- Reset, then push 3 entries (instr=1,2,3; len=10,20,30) -> count=3, pending_bytes=60, head {1,10}; pop -> head {2,20}, pending_bytes=50, free=DEPTH-2.
- DEPTH=32, AFULL_THRESH=4: push 28 -> almost_full=1, full=0; push 4 more -> full=1, free=0; push {7,99} while full -> overflow=1, count=32, pending_bytes unchanged.
- Full queue, wr_en and rd_en in the same cycle -> read accepted, write dropped, count=31, overflow=1; err_clr -> overflow=0.
- Empty queue, wr_en {5,8} and rd_en in the same cycle -> count=1, head {5,8}, underflow=1.
- Push/pop 100 entries with 1-cycle spacing, continuously with both asserted -> data order exact across multiple pointer wraps, pending_bytes matches the model every cycle, count never exceeds 1.
- 10 entries queued; flush with wr_en=1 in the same cycle -> empty=1, count=0, pending_bytes=0, overflow unchanged. Then rst mid-stream -> all outputs at reset values the next cycle.
